rckt_trace_buffer: RTL and testbench
====================================

Name: rckt_trace_buffer

Overview:
- Downstream consumer of the packed Rocket tile's commit broadcast: `auto_broadcast_out_valid_o` plus the `rocket_bcast_packed_t` packet.
- The broadcast has no backpressure. This block absorbs it into a small FIFO and re-issues packets on a valid/ready trace interface toward the trace sink or debug DMA.
- When the FIFO is full, packets are dropped. Each drop is counted, and the loss count is reported alongside the next packet that is accepted.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, >= 2
- DROP_W, 8, width of the per-entry gap (lost-packet) counter; saturating

Ports:
- clock_i  in  1  clock
- reset_ni  in  1  reset; synchronous, active-low
- bcast_valid_i  in  1  commit broadcast valid
- bcast_packet_i  in  rocket_bcast_packed_t (197)  packed commit record: iaddr, insn, priv, exception, interrupt, cause, tval, time
- trace_valid_o  out  1  head entry available
- trace_ready_i  in  1  sink accepts head
- trace_packet_o  out  197  head packet
- trace_gap_o  out  DROP_W  packets lost immediately before the head packet
- level_o  out  $clog2(DEPTH)+1  current occupancy
- overflow_o  out  1  sticky; set on any drop since reset

Behaviour:
- Reset (reset_ni low at a rising clock edge):
  - rd/wr pointers, count, drop counter, overflow_o and state are cleared; state goes to NORMAL.
  - All outputs read 0 in the cycle after reset, except trace_packet_o/trace_gap_o, which hold the head memory contents (don't-care while trace_valid_o=0).
  - Reset mid-stream discards all stored entries. A reset_ni change between clock edges has no effect.
- Handshake and control terms:
  - pop = trace_valid_o & trace_ready_i
  - push_ok = capture & ((count < DEPTH) | pop)
  - capture = bcast_valid_i (see Optional Feature)
- Ordering and latency:
  - Entries leave in push order.
  - A packet accepted at edge N appears on trace_* from edge N (latency 1 clock). No bypass from bcast_packet_i to trace_packet_o.
- Output stability:
  - trace_valid_o = (count != 0).
  - While trace_valid_o=1 and trace_ready_i=0, trace_packet_o/trace_gap_o are stable and trace_valid_o stays high.
- Full with simultaneous pop: the push is accepted. count is unchanged, the write goes to the slot freed by the pop, and no drop occurs.
- Empty with simultaneous pop: impossible, since trace_valid_o=0.
- Drop path (capture & !push_ok):
  - drop_cnt <= min(drop_cnt+1, 2^DROP_W-1).
  - overflow_o <= 1.
  - state <= DROPPING.
- Accept path (push_ok):
  - Entry = {gap=drop_cnt, packet}.
  - drop_cnt <= 0.
  - state <= NORMAL.
  - An accept in DROPPING therefore tags the first post-loss packet with the number of lost packets.
- States:
  - NORMAL: drop_cnt == 0.
  - DROPPING: drop_cnt > 0 (losses pending report).
  - Transitions are only those given in the drop and accept paths. No packet arrival means no state change.
- Pointers: log2(DEPTH) bits, wrap naturally; count is $clog2(DEPTH)+1 bits.
- level_o = count, registered.

Optional Feature:
- Macro RCKT_TRACE_EXC_ONLY_EN.
- Defined: capture = bcast_valid_i & (packet.exception | packet.interrupt).
  - Non-trap commits are ignored entirely: not stored, not counted as drops, no state change.
- Undefined: capture = bcast_valid_i; every broadcast packet is captured.

Decomposition:
- Add to the shared rocket_trace_pkg, alongside existing rocket_bcast_t / rocket_bcast_packed_t usage:
  - trace_entry_t, a packed struct {gap [DROP_W], rocket_bcast_packed_t packet}
  - trace_state_e enum {NORMAL, DROPPING}
- One sub-module, rckt_trace_fifo:
  - Generic single-clock show-ahead FIFO with push/pop/count; push-while-full-and-popping is allowed.
  - The top handles capture, drop counting, state and gap tagging.

Test Plan:
- DEPTH=8, trace_ready_i=1: push 3 back-to-back packets, iaddr 0x80000000/04/08 → trace_valid_o rises 1 cycle after the first push; all 3 are output in order with gap=0; level_o peaks at 1; overflow_o=0.
- trace_ready_i=0: push 10 packets → level_o=8, packets 9-10 dropped, overflow_o=1. Then trace_ready_i=1, drain, push iaddr 0x80000100 → that packet is output with gap=2, after 8 entries with gap=0.
- FIFO full (8) with trace_ready_i=1 and a push in the same cycle → push accepted; level_o stays 8; overflow_o stays 0; output order preserved.
- DROP_W=8, FIFO full, ready=0: 300 drops, then drain one entry and push → the new entry's gap=255 (saturated); a subsequent push has gap=0.
- level_o=5 mid-stream: reset_ni low for one edge → next cycle trace_valid_o=0, level_o=0, overflow_o=0. A reset_ni pulse between edges changes nothing. Backpressure-stability check during ready=0 runs throughout.
- RCKT_TRACE_EXC_ONLY_EN defined, FIFO full, ready=0: a packet with exception=0 → no drop, overflow_o=0. A packet with exception=1, cause=0x2 → counted as a drop. With FIFO not full, a packet with interrupt=1, cause=0x80000007 → enqueued and output with gap reflecting only trap drops.

Source files
------------

// File: rtl/rocket_trace_pkg.sv
// Shared Rocket trace types: packed commit broadcast record, buffered trace entry and
// trace-buffer drop-reporting state.
package rocket_trace_pkg;

  localparam int unsigned TRACE_DROP_W = 8;

  typedef struct packed {
    logic [39:0] iaddr;
    logic [31:0] insn;
    logic [2:0]  priv;
    logic        exception;
    logic        interrupt;
    logic [63:0] cause;
    logic [39:0] tval;
    logic [15:0] tstamp;
  } rocket_bcast_packed_t;

  typedef struct packed {
    logic [TRACE_DROP_W-1:0] gap;
    rocket_bcast_packed_t    packet;
  } trace_entry_t;

  typedef enum logic [0:0] {
    NORMAL   = 1'b0,
    DROPPING = 1'b1
  } trace_state_e;

  function automatic logic is_trap(input rocket_bcast_packed_t p);
    return p.exception | p.interrupt;
  endfunction

endpackage

// File: rtl/rckt_trace_buffer_if.sv
// Commit-broadcast input and valid/ready trace output bundle of the trace buffer.
// master = broadcast source / trace sink side, slave = rckt_trace_buffer.
interface rckt_trace_buffer_if #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
);
  import rocket_trace_pkg::*;

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                 bcast_valid_i;
  rocket_bcast_packed_t bcast_packet_i;
  logic                 trace_valid_o;
  logic                 trace_ready_i;
  rocket_bcast_packed_t trace_packet_o;
  logic [DROP_W-1:0]    trace_gap_o;
  logic [LVL_W-1:0]     level_o;
  logic                 overflow_o;

  modport master (
    output bcast_valid_i, bcast_packet_i, trace_ready_i,
    input  trace_valid_o, trace_packet_o, trace_gap_o, level_o, overflow_o
  );

  modport slave (
    input  bcast_valid_i, bcast_packet_i, trace_ready_i,
    output trace_valid_o, trace_packet_o, trace_gap_o, level_o, overflow_o
  );

endinterface

// File: rtl/rckt_trace_fifo.sv
// Single-clock show-ahead FIFO; head word is visible on o_data without a pop.
// A push while full is legal only when a pop happens in the same cycle.
module rckt_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset: contents are don't-care while empty
  always_ff @(posedge clk_i) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/rckt_trace_buffer.sv
// Absorbs the backpressure-free Rocket commit broadcast into a FIFO, counts packets lost
// while full and tags the next accepted packet with that gap. Build option:
// RCKT_TRACE_EXC_ONLY_EN captures only exception/interrupt commits.
module rckt_trace_buffer
  import rocket_trace_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  rckt_trace_buffer_if.slave bus
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = DROP_W + $bits(rocket_bcast_packed_t);
  localparam logic [LVL_W-1:0]  DEPTH_L  = LVL_W'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  logic              w_capture;
  logic              w_pop;
  logic              w_push_ok;
  logic              w_drop;
  logic [LVL_W-1:0]  w_count;
  logic [ENT_W-1:0]  w_wdata;
  logic [ENT_W-1:0]  w_rdata;

  trace_state_e      r_state;
  trace_state_e      w_state_next;
  logic [DROP_W-1:0] r_drop_cnt;
  logic [DROP_W-1:0] w_drop_next;
  logic              r_overflow;
  logic              w_overflow_next;

`ifdef RCKT_TRACE_EXC_ONLY_EN
  assign w_capture = bus.bcast_valid_i & is_trap(bus.bcast_packet_i);
`else
  assign w_capture = bus.bcast_valid_i;
`endif

  assign bus.trace_valid_o = (w_count != {LVL_W{1'b0}});
  assign w_pop             = bus.trace_valid_o & bus.trace_ready_i;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign w_push_ok         = w_capture & ((w_count < DEPTH_L) | w_pop);
  assign w_drop            = w_capture & ~w_push_ok;
  assign w_wdata           = {r_drop_cnt, bus.bcast_packet_i};

  rckt_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk_i   (clock_i),
    .rst_ni  (reset_ni),
    .i_push  (w_push_ok),
    .i_pop   (w_pop),
    .i_data  (w_wdata),
    .o_data  (w_rdata),
    .o_count (w_count)
  );

  // Drop-reporting state, gap counter and sticky overflow registers
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      r_state    <= NORMAL;
      r_drop_cnt <= {DROP_W{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_drop_cnt <= w_drop_next;
      r_overflow <= w_overflow_next;
    end
  end

  // Next state: an accept reports and clears pending losses, a drop adds one (saturating)
  always_comb begin
    w_state_next    = r_state;
    w_drop_next     = r_drop_cnt;
    w_overflow_next = r_overflow;
    case (r_state)
      NORMAL: begin
        if (w_push_ok) begin
          w_drop_next = {DROP_W{1'b0}};
        end else if (w_drop) begin
          w_state_next    = DROPPING;
          w_drop_next     = {{(DROP_W-1){1'b0}}, 1'b1};
          w_overflow_next = 1'b1;
        end else begin
          w_state_next = NORMAL;
        end
      end
      DROPPING: begin
        if (w_push_ok) begin
          w_state_next = NORMAL;
          w_drop_next  = {DROP_W{1'b0}};
        end else if (w_drop) begin
          w_overflow_next = 1'b1;
          w_drop_next     = (r_drop_cnt == DROP_MAX) ? DROP_MAX
                                                     : r_drop_cnt + DROP_W'(1);
        end else begin
          w_state_next = DROPPING;
        end
      end
      default: begin
        w_state_next = NORMAL;
        w_drop_next  = {DROP_W{1'b0}};
      end
    endcase
  end

  assign {bus.trace_gap_o, bus.trace_packet_o} = w_rdata;
  assign bus.level_o    = w_count;
  assign bus.overflow_o = r_overflow;

endmodule

// File: tb/tb_rckt_trace_buffer.sv
// Self-checking bench for rckt_trace_buffer: table-driven basic flow, then hand-written
// overflow, full-with-pop, gap saturation, reset and (optionally) trap-only sequences.
module tb_rckt_trace_buffer;
  import rocket_trace_pkg::*;

  localparam int DEPTH  = 8;
  localparam int DROP_W = 8;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DROP_W-1:0]    gap;
    rocket_bcast_packed_t packet;
  } exp_t;

  typedef struct {
    logic             v;
    logic [39:0]      iaddr;
    logic             rdy;
    logic             exp_valid;
    logic [LVL_W-1:0] exp_level;
    logic             exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rckt_trace_buffer_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

  rckt_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clock_i  (clk),
    .reset_ni (reset_n),
    .bus      (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  int   m_count  = 0;
  int   m_drop   = 0;
  logic m_ovf    = 1'b0;
  logic prev_stall = 1'b0;
  rocket_bcast_packed_t prev_pkt;
  logic [DROP_W-1:0]    prev_gap;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rocket_bcast_packed_t mk_pkt(input logic [39:0] ia, input logic exc,
                                                  input logic intr, input logic [63:0] cause);
    rocket_bcast_packed_t p;
    p.iaddr     = ia;
    p.insn      = ia[31:0] ^ 32'h0000_0013;
    p.priv      = 3'd3;
    p.exception = exc;
    p.interrupt = intr;
    p.cause     = cause;
    p.tval      = {ia[7:0], 32'hCAFE_0000};
    p.tstamp    = ia[15:0] ^ 16'hA5A5;
    return p;
  endfunction

  function automatic rocket_bcast_packed_t gen_pkt(input logic [39:0] ia);
    return mk_pkt(ia, 1'b1, 1'b0, {24'h0, ia});
  endfunction

  // One clock: drive at the falling edge, check outputs against the model, advance the model
  task automatic step(input logic v, input rocket_bcast_packed_t p, input logic rdy,
                      input logic rst);
    logic cap;
    logic mpop;
    exp_t e;
    @(negedge clk);
    reset_n            = rst;
    bus.bcast_valid_i  = v;
    bus.bcast_packet_i = p;
    bus.trace_ready_i  = rdy;
    #1;
    chk("trace_valid", bus.trace_valid_o, (m_count != 0));
    chk("level", bus.level_o, m_count);
    chk("overflow", bus.overflow_o, m_ovf);
    if (prev_stall) begin
      chk("stall_valid", bus.trace_valid_o, 1'b1);
      chk("stall_packet", bus.trace_packet_o, prev_pkt);
      chk("stall_gap", bus.trace_gap_o, prev_gap);
    end
    prev_stall = rst && bus.trace_valid_o && !rdy;
    prev_pkt   = bus.trace_packet_o;
    prev_gap   = bus.trace_gap_o;
    if (!rst) begin
      m_count = 0;
      m_drop  = 0;
      m_ovf   = 1'b0;
      sb_q.delete();
    end else begin
      mpop = (m_count != 0) && rdy;
      if (mpop) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("out_packet", bus.trace_packet_o, e.packet);
          chk("out_gap", bus.trace_gap_o, e.gap);
        end
      end
`ifdef RCKT_TRACE_EXC_ONLY_EN
      cap = v && (p.exception || p.interrupt);
`else
      cap = v;
`endif
      if (cap) begin
        if (m_count < DEPTH || mpop) begin
          e.gap    = DROP_W'(m_drop);
          e.packet = p;
          sb_q.push_back(e);
          m_drop = 0;
          m_count++;
        end else begin
          m_drop = (m_drop >= (1 << DROP_W) - 1) ? (1 << DROP_W) - 1 : m_drop + 1;
          m_ovf  = 1'b1;
        end
      end
      if (mpop) m_count--;
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) step(1'b0, '0, rdy, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic push_n(input int n, input logic [39:0] base, input logic rdy);
    for (int k = 0; k < n; k++) step(1'b1, gen_pkt(base + 40'(4 * k)), rdy, 1'b1);
  endtask

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n            = 1'b0;
    bus.bcast_valid_i  = 1'b0;
    bus.bcast_packet_i = '0;
    bus.trace_ready_i  = 1'b0;
    do_reset();

    // Basic flow: three back-to-back packets, sink always ready
    vecs[0] = '{1'b1, 40'h00_8000_0000, 1'b1, 1'b0, 4'd0, 1'b0};
    vecs[1] = '{1'b1, 40'h00_8000_0004, 1'b1, 1'b1, 4'd1, 1'b0};
    vecs[2] = '{1'b1, 40'h00_8000_0008, 1'b1, 1'b1, 4'd1, 1'b0};
    vecs[3] = '{1'b0, 40'h00_0000_0000, 1'b1, 1'b1, 4'd1, 1'b0};
    vecs[4] = '{1'b0, 40'h00_0000_0000, 1'b1, 1'b0, 4'd0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      step(vecs[i].v, vecs[i].v ? gen_pkt(vecs[i].iaddr) : '0, vecs[i].rdy, 1'b1);
      chk("tbl_valid", bus.trace_valid_o, vecs[i].exp_valid);
      chk("tbl_level", bus.level_o, vecs[i].exp_level);
      chk("tbl_ovf", bus.overflow_o, vecs[i].exp_ovf);
    end
    chk("t1_drained", sb_q.size(), 0);

    // Overflow: ten pushes into a stalled FIFO, drain, then report gap=2
    do_reset();
    push_n(10, 40'h00_8000_0040, 1'b0);
    idle(1, 1'b0);
    chk("t2_level_full", bus.level_o, 4'd8);
    chk("t2_ovf", bus.overflow_o, 1'b1);
    idle(8, 1'b1);
    step(1'b1, gen_pkt(40'h00_8000_0100), 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("t2_drained", sb_q.size(), 0);

    // Full FIFO with pop and push in the same cycle: no drop, order kept
    do_reset();
    push_n(8, 40'h00_8000_0200, 1'b0);
    push_n(4, 40'h00_8000_0300, 1'b1);
    idle(1, 1'b0);
    chk("t3_level", bus.level_o, 4'd8);
    chk("t3_ovf", bus.overflow_o, 1'b0);
    idle(9, 1'b1);
    chk("t3_drained", sb_q.size(), 0);

    // Gap saturation: 300 drops, then replace-on-pop gets gap=255, next gets 0
    do_reset();
    push_n(8, 40'h00_8000_0400, 1'b0);
    push_n(300, 40'h00_9000_0000, 1'b0);
    step(1'b1, gen_pkt(40'h00_8000_0500), 1'b1, 1'b1);
    step(1'b1, gen_pkt(40'h00_8000_0504), 1'b1, 1'b1);
    idle(10, 1'b1);
    chk("t4_drained", sb_q.size(), 0);

    // Reset mid-stream, and a reset glitch between edges that must be ignored
    do_reset();
    push_n(5, 40'h00_8000_0600, 1'b0);
    idle(1, 1'b0);
    chk("t5_level5", bus.level_o, 4'd5);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    idle(1, 1'b0);
    chk("t5_glitch_level", bus.level_o, 4'd5);
    step(1'b0, '0, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("t5_rst_valid", bus.trace_valid_o, 1'b0);
    chk("t5_rst_level", bus.level_o, 4'd0);
    chk("t5_rst_ovf", bus.overflow_o, 1'b0);

`ifdef RCKT_TRACE_EXC_ONLY_EN
    // Trap-only capture: non-trap commits are neither stored nor counted as drops
    do_reset();
    push_n(8, 40'h00_8000_0700, 1'b0);
    step(1'b1, mk_pkt(40'h00_8000_0800, 1'b0, 1'b0, 64'h0), 1'b0, 1'b1);
    idle(1, 1'b0);
    chk("t6_ovf_nontrap", bus.overflow_o, 1'b0);
    step(1'b1, mk_pkt(40'h00_8000_0804, 1'b1, 1'b0, 64'h2), 1'b0, 1'b1);
    idle(1, 1'b0);
    chk("t6_ovf_trap", bus.overflow_o, 1'b1);
    idle(1, 1'b1);
    step(1'b1, mk_pkt(40'h00_8000_0808, 1'b0, 1'b0, 64'h0), 1'b0, 1'b1);
    step(1'b1, mk_pkt(40'h00_8000_080C, 1'b0, 1'b1, 64'h8000_0007), 1'b0, 1'b1);
    idle(10, 1'b1);
    chk("t6_drained", sb_q.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
